// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller for a 5-stage in-order core.
// Latency: all enables are combinational from state+inputs (zero-cycle); state, counters update on clk_i rise.
// Backpressure: mem_busy_i freezes the whole pipe (pipe_hold_o) ahead of load-use hazard and branch flush.
//
// Ports:
//   clk_i, rst_i (async, active-low)      clock and reset
//   start_i                               core run enable; 0 returns to IDLE from any state
//   idex_memread_i, idex_rd_i             load in EX and its destination register
//   ifid_rs_i, ifid_rt_i                  source registers of the instruction in ID
//   branch_taken_i, mem_busy_i            branch resolved taken in ID / data memory not ready
//   pc_write_o, ifid_write_o              PC and IF/ID update enables
//   ifid_flush_o, idex_bubble_o           zero IF/ID, insert NOP into ID/EX
//   pipe_hold_o                           freeze ID/EX, EX/MEM, MEM/WB
//   state_o, stall_cnt_o, mem_timeout_o   FSM state, saturating stall count, sticky wait timeout
module stall_ctrl #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rd_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             branch_taken_i,
    input  logic             mem_busy_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic             pipe_hold_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             mem_timeout_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_MEMW = 2'd2;

    localparam int              WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    logic [1:0]        state_q;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_inc;
    logic              timeout_q;
    logic              hazard;
    logic              active;
    logic              wait_step;

    // Load-use hazard: register 0 never carries a real dependency.
    assign hazard = idex_memread_i && (idex_rd_i != 5'd0) &&
                    ((idex_rd_i == ifid_rs_i) || (idex_rd_i == ifid_rt_i));

    // MEMW with memory ready behaves exactly like RUN for the outputs, so
    // both states share one decode; a dropped start_i suppresses everything.
    assign active = ((state_q == ST_RUN) || (state_q == ST_MEMW)) && start_i;

    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        pipe_hold_o   = 1'b0;
        if (active) begin
            if (mem_busy_i) begin
                pipe_hold_o = 1'b1;
            end else if (hazard) begin
                idex_bubble_o = 1'b1;
            end else begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                ifid_flush_o = branch_taken_i;
            end
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        case (state_q)
            ST_IDLE: state_nxt = start_i ? ST_RUN : ST_IDLE;
            ST_RUN, ST_MEMW: begin
                if (!start_i)        state_nxt = ST_IDLE;
                else if (mem_busy_i) state_nxt = ST_MEMW;
                else                 state_nxt = ST_RUN;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Wait counter advances only on busy cycles spent in MEMW and stops at the limit.
    assign wait_step = (state_q == ST_MEMW) && start_i && mem_busy_i && (wait_cnt_q != WAIT_MAX);
    assign wait_inc  = wait_cnt_q + WAIT_W'(1);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            stall_cnt_q <= '0;
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;

            if (state_q == ST_IDLE) begin
                if (start_i) stall_cnt_q <= '0;
            end else if (active && !pc_write_o && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end

            if ((state_q != ST_MEMW) && (state_nxt == ST_MEMW)) begin
                wait_cnt_q <= '0;
            end else if (wait_step) begin
                wait_cnt_q <= wait_inc;
            end

            // Sticky: only reset clears it.
            if (wait_step && (wait_inc == WAIT_MAX)) timeout_q <= 1'b1;
        end
    end

    assign state_o       = state_q;
    assign stall_cnt_o   = stall_cnt_q;
    assign mem_timeout_o = timeout_q;

endmodule
